// File: rtl/xor_gate_core.sv
// Bitwise XOR leaf primitive: combinational result, registered copy with valid,
// parity of the registered result and a saturating count of differing cycles.
module xor_gate_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             in_valid,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             parity,
  output logic [CNT_W-1:0] diff_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      return cnt;
    end
    return cnt + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] xor_w;
  logic [WIDTH-1:0] out_q_d;
  logic [WIDTH-1:0] out_q_q;
  logic             out_valid_d;
  logic             out_valid_q;
  logic [CNT_W-1:0] diff_cnt_d;
  logic [CNT_W-1:0] diff_cnt_q;

  assign xor_w = inA ^ inB;
  assign out   = xor_w;

  always_comb begin
    out_q_d     = out_q_q;
    out_valid_d = in_valid;
    diff_cnt_d  = diff_cnt_q;
    if (in_valid) begin
      out_q_d = xor_w;
    end
    // Clear wins over a same-cycle increment.
    if (clr_cnt) begin
      diff_cnt_d = '0;
    end else if (in_valid && (|xor_w)) begin
      diff_cnt_d = sat_inc(diff_cnt_q);
    end
  end

  // Input -> registered stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
      diff_cnt_q  <= '0;
    end else begin
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
      diff_cnt_q  <= diff_cnt_d;
    end
  end

  assign out_q     = out_q_q;
  assign out_valid = out_valid_q;
  assign parity    = ^out_q_q;
  assign diff_cnt  = diff_cnt_q;

endmodule

// File: tb/tb_xor_gate_core.sv
// Bench for xor_gate_core: a 1-bit instance for the combinational/reset cases and
// an 8-bit, 2-bit-counter instance checked against a behavioural model every cycle.
module tb_xor_gate_core;

  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;

  int total = 0;
  int bad = 0;

  // 1-bit instance
  logic [0:0]  a1, b1, out1, outq1;
  logic        v1, clr1, ov1, par1;
  logic [15:0] cnt1;

  // 8-bit instance with a 2-bit counter
  logic [7:0]  a8, b8, out8, outq8;
  logic        v8, clr8, ov8, par8;
  logic [1:0]  cnt8;

  // Behavioural model of the 8-bit instance
  logic [7:0]  m_q;
  logic        m_v;
  int          m_c;
  localparam int M_MAX = 3;

  always #5 if (clk_run) clk = ~clk;

  xor_gate_core #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .inA(a1), .inB(b1), .in_valid(v1), .clr_cnt(clr1),
    .out(out1), .out_q(outq1), .out_valid(ov1), .parity(par1), .diff_cnt(cnt1)
  );

  xor_gate_core #(.WIDTH(8), .CNT_W(2)) u_w8 (
    .clk(clk), .rst_n(rst_n), .inA(a8), .inB(b8), .in_valid(v8), .clr_cnt(clr8),
    .out(out8), .out_q(outq8), .out_valid(ov8), .parity(par8), .diff_cnt(cnt8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accepted operands are remembered, counter counts accepted unequal pairs up to M_MAX.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 8'h00;
      m_v <= 1'b0;
      m_c <= 0;
    end else begin
      m_v <= v8;
      if (v8) m_q <= a8 ^ b8;
      if (clr8) m_c <= 0;
      else if (v8 && (a8 != b8) && (m_c < M_MAX)) m_c <= m_c + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_out",    64'(out8),  64'(a8 ^ b8));
      chk("cmp_out_q",  64'(outq8), 64'(m_q));
      chk("cmp_valid",  64'(ov8),   64'(m_v));
      chk("cmp_parity", 64'(par8),  64'($countones(m_q) % 2));
      chk("cmp_cnt",    64'(cnt8),  64'(m_c));
    end
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic v, input logic c);
    a8 = a; b8 = b; v8 = v; clr8 = c;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [0:0] va [4];
  logic [0:0] vb [4];
  logic [0:0] vo [4];
  int sat_exp [5];

  initial begin
    va = '{1'b0, 1'b1, 1'b0, 1'b1};
    vb = '{1'b0, 1'b0, 1'b1, 1'b1};
    vo = '{1'b0, 1'b1, 1'b1, 1'b0};
    sat_exp = '{1, 2, 3, 3, 3};

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0; clr1 = 1'b0;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);

    // Combinational path with the clock stopped and reset held
    for (int i = 0; i < 4; i++) begin
      a1 = va[i]; b1 = vb[i];
      #100;
      chk("w1_comb_out", 64'(out1), 64'(vo[i]));
    end

    // Reset held with the clock running
    clk_run = 1'b1;
    a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    chk("w1_rst_out",    64'(out1),  64'h1);
    chk("w1_rst_out_q",  64'(outq1), 64'h0);
    chk("w1_rst_valid",  64'(ov1),   64'h0);
    chk("w1_rst_cnt",    64'(cnt1),  64'h0);
    chk("w1_rst_parity", 64'(par1),  64'h0);
    rst_n = 1'b1;
    tick();
    chk("w1_rel_out_q", 64'(outq1), 64'h1);
    chk("w1_rel_valid", 64'(ov1),   64'h1);
    chk("w1_rel_cnt",   64'(cnt1),  64'h1);
    v1 = 1'b0;

    // 8-bit XOR and parity
    drive8(8'hA5, 8'h0F, 1'b1, 1'b0);
    #1;
    chk("w8_out_imm", 64'(out8), 64'hAA);
    tick();
    chk("w8_out_q_aa",  64'(outq8), 64'hAA);
    chk("w8_parity_aa", 64'(par8),  64'h0);
    drive8(8'hA5, 8'h0E, 1'b1, 1'b0);
    tick();
    chk("w8_out_q_ab",  64'(outq8), 64'hAB);
    chk("w8_parity_ab", 64'(par8),  64'h1);
    chk("w8_cnt_two",   64'(cnt8),  64'h2);

    // Invalid cycles hold the registered result
    drive8(8'hFF, 8'h00, 1'b0, 1'b0);
    repeat (3) tick();
    chk("w8_hold_out_q", 64'(outq8), 64'hAB);
    chk("w8_hold_valid", 64'(ov8),   64'h0);
    chk("w8_hold_cnt",   64'(cnt8),  64'h2);
    chk("w8_hold_out",   64'(out8),  64'hFF);

    // Saturation and clear
    drive8(8'hFF, 8'h00, 1'b0, 1'b1);
    tick();
    chk("w8_clr_idle", 64'(cnt8), 64'h0);
    drive8(8'h01, 8'h02, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w8_sat_cnt", 64'(cnt8), 64'(sat_exp[i]));
    end
    drive8(8'h01, 8'h02, 1'b1, 1'b1);
    tick();
    chk("w8_clr_prio", 64'(cnt8), 64'h0);

    // Equal operands leave the counter alone
    drive8(8'h01, 8'h02, 1'b1, 1'b0);
    tick();
    drive8(8'h3C, 8'h3C, 1'b1, 1'b0);
    repeat (4) tick();
    chk("w8_eq_cnt",    64'(cnt8),  64'h1);
    chk("w8_eq_out",    64'(out8),  64'h0);
    chk("w8_eq_out_q",  64'(outq8), 64'h0);
    chk("w8_eq_parity", 64'(par8),  64'h0);

    // Asynchronous reset mid-operation
    drive8(8'hF0, 8'h0F, 1'b1, 1'b0);
    tick();
    chk("w8_pre_rst_cnt", 64'(cnt8), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("w8_arst_out_q", 64'(outq8), 64'h0);
    chk("w8_arst_valid", 64'(ov8),   64'h0);
    chk("w8_arst_cnt",   64'(cnt8),  64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("w8_post_rst_out_q", 64'(outq8), 64'hFF);
    chk("w8_post_rst_cnt",   64'(cnt8),  64'h1);

    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_gate_core.md
Name: xor_gate_core

Overview:
Bitwise XOR of two operand vectors. Provides a zero-latency combinational result and a registered copy of that result with valid tracking. Also provides a reduction-parity flag and a saturating count of cycles in which the two operands differed. Used as a leaf comparison/parity primitive in datapath blocks.

Parameters:
WIDTH, 1, operand and result width in bits (legal range 1..64)
CNT_W, 16, width of the mismatch counter (legal range 1..32)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
inA  input  WIDTH  operand A
inB  input  WIDTH  operand B
in_valid  input  1  qualifies inA/inB for the registered path and counter
clr_cnt  input  1  synchronous clear of diff_cnt
out  output  WIDTH  combinational inA ^ inB
out_q  output  WIDTH  registered inA ^ inB
out_valid  output  1  registered copy of in_valid
parity  output  1  reduction XOR of out_q
diff_cnt  output  CNT_W  saturating count of accepted cycles with out != 0

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- out = inA ^ inB, bitwise and purely combinational.
  - No clock dependency and no reset dependency; out is valid even while rst_n = 0.
  - Must settle within the same time step that the inputs change. A bench samples it with no clock edge in between.
- Reset (rst_n = 0) acts immediately, regardless of clk:
  - out_q = 0
  - out_valid = 0
  - diff_cnt = 0
  - parity follows out_q, so parity = 0
- Registered path, on each rising clk edge while rst_n = 1:
  - out_valid <= in_valid
  - if in_valid = 1: out_q <= inA ^ inB
  - if in_valid = 0: out_q holds its previous value
  - Latency from inputs to out_q/out_valid is exactly 1 cycle.
- parity = XOR of all bits of out_q (combinational from out_q). For WIDTH = 1, parity = out_q.
- diff_cnt, updated on each rising edge:
  - clr_cnt = 1: diff_cnt <= 0. Clear has priority over increment in the same cycle.
  - else, if in_valid = 1 and (inA ^ inB) != 0 and diff_cnt != all-ones: diff_cnt <= diff_cnt + 1
  - otherwise diff_cnt holds. It saturates at 2^CNT_W - 1 and never wraps.
- Reset asserted mid-operation clears all registers at once. The first edge after rst_n rises behaves as a normal cycle.
- X/Z on inputs is not handled specially; it propagates per standard Verilog XOR semantics.

Test Plan:
- WIDTH=1, no clock edges, inputs changed every 100 time units: (inA,inB) = (0,0), (1,0), (0,1), (1,1) -> out = 0, 1, 1, 0, each sampled 100 units after the change.
- rst_n = 0 with inA=1, inB=0 and clk toggling -> out = 1 while out_q = 0, out_valid = 0, diff_cnt = 0, parity = 0. Release reset, drive in_valid=1 -> one edge later out_q = 1, out_valid = 1, diff_cnt = 1.
- WIDTH=8, in_valid=1, inA=8'hA5, inB=8'h0F -> out = 8'hAA immediately; out_q = 8'hAA and parity = 0 after one edge. Then inB=8'h0E -> out_q = 8'hAB, parity = 1.
- in_valid=0 with inA=8'hFF, inB=8'h00 for 3 edges -> out_q holds its last value, out_valid = 0, diff_cnt unchanged, out = 8'hFF.
- CNT_W=2, in_valid=1, inputs differing for 5 edges -> diff_cnt goes 1, 2, 3, 3, 3. Then clr_cnt=1 together with differing inputs for one edge -> diff_cnt = 0.
- Equal operands (inA=inB=8'h3C) with in_valid=1 for 4 edges -> diff_cnt unchanged, out = 0, out_q = 0, parity = 0.
